// File: rtl/data_mem_copy_engine_if.sv
// Signal bundle between the copy engine, its controller and the data memory port.
// Optional checksum output present when CPY_CHECKSUM_EN is defined.
interface data_mem_copy_engine_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);
   logic              i_start;
   logic [ADDR_W-1:0] i_srcAddr;
   logic [ADDR_W-1:0] i_dstAddr;
   logic [LEN_W-1:0]  i_length;
   logic [DATA_W-1:0] i_readData;
   logic              o_busy;
   logic              o_done;
   logic              o_error;
   logic              o_memRead;
   logic              o_memWrite;
   logic [ADDR_W-1:0] o_address;
   logic [DATA_W-1:0] o_writeData;
`ifdef CPY_CHECKSUM_EN
   logic [DATA_W-1:0] o_checksum;

   modport master (
      input  i_start, i_srcAddr, i_dstAddr, i_length, i_readData,
      output o_busy, o_done, o_error, o_memRead, o_memWrite, o_address, o_writeData, o_checksum
   );
   modport slave (
      output i_start, i_srcAddr, i_dstAddr, i_length, i_readData,
      input  o_busy, o_done, o_error, o_memRead, o_memWrite, o_address, o_writeData, o_checksum
   );
`else
   modport master (
      input  i_start, i_srcAddr, i_dstAddr, i_length, i_readData,
      output o_busy, o_done, o_error, o_memRead, o_memWrite, o_address, o_writeData
   );
   modport slave (
      output i_start, i_srcAddr, i_dstAddr, i_length, i_readData,
      input  o_busy, o_done, o_error, o_memRead, o_memWrite, o_address, o_writeData
   );
`endif
endinterface

// File: rtl/data_mem_copy_engine.sv
// Block copy engine driving the single-cycle data memory port (ascending, bounds-checked).
// Define CPY_CHECKSUM_EN to add the running checksum of copied words.
module data_mem_copy_engine #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 8,
   parameter int MEM_WORDS = 100
) (
   input logic                    i_clk,
   input logic                    i_rst,
   data_mem_copy_engine_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_srcPtr;
   logic [ADDR_W-1:0] r_dstPtr;
   logic [LEN_W-1:0]  r_count;
   logic [DATA_W-1:0] r_dataReg;
   logic              r_error;
`ifdef CPY_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;
`endif

   // End addresses computed one bit wider so a range near the top of the address space cannot wrap
   logic [ADDR_W:0] w_srcEnd;
   logic [ADDR_W:0] w_dstEnd;
   logic [ADDR_W:0] w_limit;

   assign w_srcEnd = {1'b0, r_srcPtr} + (ADDR_W+1)'(r_count);
   assign w_dstEnd = {1'b0, r_dstPtr} + (ADDR_W+1)'(r_count);
   assign w_limit  = (ADDR_W+1)'(MEM_WORDS);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state   <= S_IDLE;
         r_srcPtr  <= '0;
         r_dstPtr  <= '0;
         r_count   <= '0;
         r_dataReg <= '0;
         r_error   <= 1'b0;
`ifdef CPY_CHECKSUM_EN
         r_checksum <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_srcPtr <= bus.i_srcAddr;
                  r_dstPtr <= bus.i_dstAddr;
                  r_count  <= bus.i_length;
                  r_error  <= 1'b0;
`ifdef CPY_CHECKSUM_EN
                  r_checksum <= '0;
`endif
                  r_state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (r_count == '0) begin
                  r_state <= S_DONE;
               end else if ((w_srcEnd > w_limit) || (w_dstEnd > w_limit)) begin
                  r_error <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_READ;
               end
            end
            S_READ: begin
               r_dataReg <= bus.i_readData;
               r_srcPtr  <= r_srcPtr + ADDR_W'(1);
`ifdef CPY_CHECKSUM_EN
               r_checksum <= r_checksum + bus.i_readData;
`endif
               r_state   <= S_WRITE;
            end
            S_WRITE: begin
               r_dstPtr <= r_dstPtr + ADDR_W'(1);
               r_count  <= r_count - LEN_W'(1);
               r_state  <= (r_count == LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy      = (r_state != S_IDLE);
   assign bus.o_done      = (r_state == S_DONE);
   assign bus.o_error     = (r_state == S_DONE) && r_error;
   assign bus.o_memRead   = (r_state == S_READ);
   assign bus.o_memWrite  = (r_state == S_WRITE);
   assign bus.o_address   = (r_state == S_READ)  ? r_srcPtr :
                            (r_state == S_WRITE) ? r_dstPtr : '0;
   assign bus.o_writeData = (r_state == S_WRITE) ? r_dataReg : '0;
`ifdef CPY_CHECKSUM_EN
   assign bus.o_checksum  = r_checksum;
`endif
endmodule
